// File: rtl/uart_regs_pkg.sv
// UART register map, UARTCON bit positions and the bus-master state encoding.
package uart_regs_pkg;

  // Register offsets from the UART base address.
  localparam logic [31:0] TxdOffset = 32'h0000_0000;
  localparam logic [31:0] RxdOffset = 32'h0000_0004;
  localparam logic [31:0] ConOffset = 32'h0000_0008;

  // UARTCON bit indices.
  localparam int unsigned ConTxStartBit = 0;
  localparam int unsigned ConRxEnBit    = 1;
  localparam int unsigned ConTxDoneBit  = 2;
  localparam int unsigned ConRxRdyBit   = 3;

  // UARTCON write values used by the sequences.
  localparam logic [31:0] ConTxGoVal = 32'h1 << ConTxStartBit;
  localparam logic [31:0] ConRxEnVal = 32'h1 << ConRxEnBit;
  localparam logic [31:0] ConClrVal  = 32'h0;

  typedef enum logic [3:0] {
    StIdle,
    StWrTxd,
    StWrTxGo,
    StPollTDone,
    StWrClr,
    StPollTClr,
    StWrRxEn,
    StPollRRdy,
    StRdRxd,
    StPollRClr,
    StAbort,
    StResp
  } state_e;

  // True for the states that repeatedly read UARTCON waiting on a status bit.
  function automatic logic is_poll_state(state_e st);
    return (st == StPollTDone) || (st == StPollTClr) ||
           (st == StPollRRdy)  || (st == StPollRClr);
  endfunction

  // Success condition of each poll state given the two UARTCON status bits.
  function automatic logic poll_hit(state_e st, logic tx_done, logic rx_rdy);
    logic hit;
    hit = 1'b0;
    case (st)
      StPollTDone: hit = tx_done;
      StPollTClr:  hit = !tx_done;
      StPollRRdy:  hit = rx_rdy;
      StPollRClr:  hit = !rx_rdy;
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// Host command/response channel plus the simple register bus toward the UART.
interface uart_bus_master_if;

  // Host command / response.
  logic        cmd_valid;
  logic        cmd_op;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  // Register bus; rdata is combinational in the cycle rd is high.
  logic [31:0] addr;
  logic        wr;
  logic        rd;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, addr, wr, rd, wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, addr, wr, rd, wdata
  );

endinterface

// File: rtl/uart_poll_timer.sv
// Counts unsuccessful poll reads; expired flags the last allowed read.
module uart_poll_timer #(
  parameter int unsigned TIMEOUT = 32'd1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] count_q, count_d;

  assign expired = (count_q == 32'(TIMEOUT - 32'd1));

  // Clear wins over enable; saturate at the expiry value.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// Turns host send/receive commands into register-bus sequences on the UART block.
module uart_bus_master
  import uart_regs_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 32'd1_000_000,
  parameter logic [31:0] UART_BASE = 32'h8000_0018
) (
  input logic               clk,
  input logic               reset,
  uart_bus_master_if.master bus
);

  localparam logic [31:0] TxdAddr = UART_BASE + TxdOffset;
  localparam logic [31:0] RxdAddr = UART_BASE + RxdOffset;
  localparam logic [31:0] ConAddr = UART_BASE + ConOffset;

  state_e state_q, state_d;

  logic       op_q;
  logic [7:0] txd_q;
  logic [7:0] rx_q;
  logic       err_q;

  logic        accept;
  logic        ld_rx;
  logic        set_err;
  logic        poll_clr;
  logic        poll_en;
  logic        poll_expired;
  logic        hit;

  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;

  uart_poll_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_poll_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (poll_clr),
    .enable (poll_en),
    .expired(poll_expired)
  );

  assign hit = poll_hit(state_q, bus.rdata[ConTxDoneBit], bus.rdata[ConRxRdyBit]);

  // Next-state and bus/handshake outputs, all decoded from the current state.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    addr      = '0;
    wdata     = '0;
    wr        = 1'b0;
    rd        = 1'b0;
    accept    = 1'b0;
    ld_rx     = 1'b0;
    set_err   = 1'b0;
    poll_clr  = 1'b1;
    poll_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = bus.cmd_op ? StWrRxEn : StWrTxd;
        end
      end
      StWrTxd: begin
        wr      = 1'b1;
        addr    = TxdAddr;
        wdata   = {24'b0, txd_q};
        state_d = StWrTxGo;
      end
      StWrTxGo: begin
        wr      = 1'b1;
        addr    = ConAddr;
        wdata   = ConTxGoVal;
        state_d = StPollTDone;
      end
      StPollTDone: if (hit) state_d = StWrClr;
      StWrClr: begin
        wr      = 1'b1;
        addr    = ConAddr;
        wdata   = ConClrVal;
        state_d = op_q ? StPollRClr : StPollTClr;
      end
      StPollTClr: if (hit) state_d = StResp;
      StWrRxEn: begin
        wr      = 1'b1;
        addr    = ConAddr;
        wdata   = ConRxEnVal;
        state_d = StPollRRdy;
      end
      StPollRRdy: if (hit) state_d = StRdRxd;
      StRdRxd: begin
        rd      = 1'b1;
        addr    = RxdAddr;
        ld_rx   = 1'b1;
        state_d = StWrClr;
      end
      StPollRClr: if (hit) state_d = StResp;
      StAbort: begin
        wr      = 1'b1;
        addr    = ConAddr;
        wdata   = ConClrVal;
        set_err = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Shared poll behaviour: a hit on the final allowed read still counts as success.
    if (is_poll_state(state_q)) begin
      rd       = 1'b1;
      addr     = ConAddr;
      poll_clr = 1'b0;
      if (!hit) begin
        if (poll_expired) begin
          state_d = StAbort;
        end else begin
          poll_en = 1'b1;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= 1'b0;
      txd_q <= '0;
      rx_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.cmd_op;
        txd_q <= bus.cmd_data;
        rx_q  <= '0;
        err_q <= 1'b0;
      end
      if (ld_rx) begin
        rx_q <= bus.rdata[7:0];
      end
      if (set_err) begin
        err_q <= 1'b1;
        rx_q  <= '0;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_valid ? rx_q : 8'h00;
  assign bus.rsp_err   = rsp_valid & err_q;
  assign bus.addr      = addr;
  assign bus.wdata     = wdata;
  assign bus.wr        = wr;
  assign bus.rd        = rd;

endmodule
